// File: rtl/adder_tree_pipe_pkg.sv
// Shared helpers for the pipelined adder tree. ADDER_TREE_PIPE_SIGNED_EN selects
// two's-complement operands (sign extension per level); default is unsigned.
package adder_tree_pkg;

`ifdef ADDER_TREE_PIPE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  function automatic int level_width(input int data_w, input int k);
    return data_w + k;
  endfunction

  function automatic int nodes_at(input int n_inputs, input int k);
    return n_inputs >> k;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Valid/ready bus between the sample source, the adder tree and the downstream sink.
interface adder_tree_pipe_if #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 8
);
  import adder_tree_pkg::*;

  localparam int SUM_W = level_width(DATA_W, $clog2(N_INPUTS));

  logic                         in_valid;
  logic                         in_ready;
  logic [N_INPUTS*DATA_W-1:0]   in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [SUM_W-1:0]             out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/adder_tree_pipe_level.sv
// One registered tree level: pairwise sums, each one bit wider than its inputs.
// Extension is sign or zero depending on ADDER_TREE_PIPE_SIGNED_EN (via the package).
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int IN_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             adv,
  input  logic                             vld_in,
  input  logic [N_IN*IN_W-1:0]             data_in,
  output logic                             vld_out,
  output logic [(N_IN/2)*(IN_W+1)-1:0]     data_out
);
  localparam int N_OUT = N_IN / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] sum_next;

  function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] a);
    return {SIGNED_EN & a[IN_W-1], a};
  endfunction

  always_comb begin
    sum_next = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum_next[j*OUT_W +: OUT_W] = ext(data_in[(2*j)*IN_W +: IN_W])
                                 + ext(data_in[(2*j+1)*IN_W +: IN_W]);
    end
  end

  // Data only loads behind a valid so the output keeps the last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out  <= 1'b0;
      data_out <= '0;
    end else if (adv) begin
      vld_out <= vld_in;
      if (vld_in) begin
        data_out <= sum_next;
      end
    end
  end
endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined adder tree, one register level per tree level, global stall on backpressure.
// Operand signedness follows ADDER_TREE_PIPE_SIGNED_EN.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_tree_pipe_if.slave   bus
);
  localparam int LEVELS = $clog2(N_INPUTS);
  localparam int SUM_W  = level_width(DATA_W, LEVELS);

  if (!is_pow2(N_INPUTS)) begin : g_bad_n
    $fatal(1, "adder_tree_pipe: N_INPUTS must be a power of two >= 2");
  end

  logic adv;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IN_W = level_width(DATA_W, k - 1);
    localparam int N_IN = nodes_at(N_INPUTS, k - 1);

    logic                           vin;
    logic [N_IN*IN_W-1:0]           din;
    logic                           vout;
    logic [(N_IN/2)*(IN_W+1)-1:0]   dout;

    if (k == 1) begin : g_first
      assign vin = bus.in_valid;
      assign din = bus.in_data;
    end else begin : g_next
      assign vin = g_lvl[k-1].vout;
      assign din = g_lvl[k-1].dout;
    end

    adder_tree_level #(
      .N_IN (N_IN),
      .IN_W (IN_W)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .vld_in   (vin),
      .data_in  (din),
      .vld_out  (vout),
      .data_out (dout)
    );
  end

  assign bus.out_valid = g_lvl[LEVELS].vout;
  assign bus.out_sum   = SUM_W'(g_lvl[LEVELS].dout);
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: main 8x8 instance plus 2x4 and 16x4 instances.
module tb_adder_tree_pipe;
  localparam int N     = 8;
  localparam int W     = 8;
  localparam int VW    = N * W;
  localparam int SUM_W = W + 3;

`ifdef ADDER_TREE_PIPE_SIGNED_EN
  localparam logic [W-1:0]     SINGLE_OP  = 8'h80;
  localparam logic [SUM_W-1:0] SINGLE_EXP = 11'h400;  // -1024
`else
  localparam logic [W-1:0]     SINGLE_OP  = 8'hFF;
  localparam logic [SUM_W-1:0] SINGLE_EXP = 11'h7F8;  // 2040
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [SUM_W-1:0] sb_q[$];

  adder_tree_pipe_if #(.N_INPUTS(N),  .DATA_W(W)) bus ();
  adder_tree_pipe_if #(.N_INPUTS(2),  .DATA_W(4)) bus2 ();
  adder_tree_pipe_if #(.N_INPUTS(16), .DATA_W(4)) bus16 ();

  adder_tree_pipe #(.N_INPUTS(N),  .DATA_W(W)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
  adder_tree_pipe #(.N_INPUTS(2),  .DATA_W(4)) dut_n2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
  adder_tree_pipe #(.N_INPUTS(16), .DATA_W(4)) dut_n16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SUM_W-1:0] model_sum(input logic [VW-1:0] v);
    int acc;
    logic [W-1:0] op;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      op = v[i*W +: W];
`ifdef ADDER_TREE_PIPE_SIGNED_EN
      acc += int'($signed(op));
`else
      acc += int'(op);
`endif
    end
    return acc[SUM_W-1:0];
  endfunction

  // Presents v until accepted, then pushes its expected sum; waited = cycles spent stalled.
  task automatic send(input logic [VW-1:0] v, input logic [SUM_W-1:0] exp, output int waited);
    bit r;
    bit ok;
    ok = 0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      if (r) begin
        ok = 1;
        break;
      end
      waited++;
    end
    if (ok) begin
      sb_q.push_back(exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: vector %h never accepted", v);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int budget, input bit rand_ready,
                         input bit contiguous, input string name);
    int got;
    int cyc;
    logic [SUM_W-1:0] exp;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got sum %h, expected no output", name, bus.out_sum);
        end else begin
          exp = sb_q.pop_front();
          if (bus.out_sum !== exp) begin
            errors++;
            $display("FAIL %s_sum: got %h, expected %h", name, bus.out_sum, exp);
          end
        end
        got++;
      end else if (contiguous && got > 0) begin
        checks++;
        errors++;
        $display("FAIL %s_gap: out_valid=%b after %0d outputs, expected 1", name, bus.out_valid, got);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, expected %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    #3;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    if (bus.out_sum !== '0) begin
      errors++; $display("FAIL reset_out_sum: got %h, expected 0", bus.out_sum);
    end
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    bit seen;
    logic [SUM_W-1:0] s;
    bus.in_valid = 1'b1;
    bus.in_data  = {N{SINGLE_OP}};
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready: got %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    seen = 0;
    s = '0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1; lat = c; s = bus.out_sum;
      end else begin
        @(posedge clk);
      end
    end
    checks += 3;
    if (lat != 3) begin
      errors++; $display("FAIL single_latency: got %0d, expected 3", lat);
    end
    if (s !== SINGLE_EXP) begin
      errors++; $display("FAIL single_sum: got %h, expected %h", s, SINGLE_EXP);
    end
    @(negedge clk);
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_one_cycle: out_valid got %b, expected 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_patterns();
    logic [VW-1:0] v;
    int w;
    int vals[N] = '{1, -1, 2, -2, 3, -3, 4, -4};
    for (int i = 0; i < N; i++) v[i*W +: W] = vals[i][W-1:0];
    fork
      begin
        send(v, model_sum(v), w);
        for (int k = 0; k < 12; k++) begin
          v = {$urandom, $urandom};
          send(v, model_sum(v), w);
        end
      end
      collect(13, 400, 1'b1, 1'b0, "patterns");
    join
    bus.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] v;
    int w;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          for (int j = 0; j < N; j++) v[j*W +: W] = W'(i + j);
          send(v, SUM_W'(8 * i + 28), w);
          checks++;
          if (w != 0) begin
            errors++; $display("FAIL b2b_in_ready: vector %0d stalled %0d cycles, expected 0", i, w);
          end
        end
      end
      collect(16, 60, 1'b0, 1'b1, "b2b");
    join
  endtask

  task automatic test_stall();
    logic [VW-1:0] v;
    logic [SUM_W-1:0] held;
    int w;
    for (int i = 0; i < 3; i++) begin
      v = {$urandom, $urandom};
      send(v, model_sum(v), w);
    end
    held = sb_q[0];
    bus.out_ready = 1'b0;
    v = {$urandom, $urandom};
    fork
      send(v, model_sum(v), w);
      begin
        repeat (5) begin
          @(negedge clk);
          checks += 3;
          if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_in_ready: got %b, expected 0", bus.in_ready);
          end
          if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_out_valid: got %b, expected 1", bus.out_valid);
          end
          if (bus.out_sum !== held) begin
            errors++; $display("FAIL stall_out_sum: got %h, expected %h", bus.out_sum, held);
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      collect(4, 40, 1'b0, 1'b0, "stall");
    join
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_duplicate: out_valid got %b, expected 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_inflight();
    logic [VW-1:0] v;
    int w;
    for (int i = 0; i < 2; i++) begin
      v = {$urandom, $urandom};
      send(v, model_sum(v), w);
    end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid);
    end
    if (bus.out_sum !== '0) begin
      errors++; $display("FAIL rst_out_sum: got %h, expected 0", bus.out_sum);
    end
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_stale: out_valid got %b at cycle %0d, expected 0", bus.out_valid, c);
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_widths();
    int lat2;
    int lat16;
    logic [4:0] s2;
    logic [7:0] s16;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = '1;
    bus16.in_valid = 1'b1;
    bus16.in_data  = '1;
    @(negedge clk);
    checks += 2;
    if (bus2.in_ready !== 1'b1) begin
      errors++; $display("FAIL n2_in_ready: got %b, expected 1", bus2.in_ready);
    end
    if (bus16.in_ready !== 1'b1) begin
      errors++; $display("FAIL n16_in_ready: got %b, expected 1", bus16.in_ready);
    end
    @(posedge clk);
    #1;
    bus2.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
    lat2 = 0; lat16 = 0; s2 = '0; s16 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus2.out_valid && lat2 == 0) begin
        lat2 = c; s2 = bus2.out_sum;
      end
      if (bus16.out_valid && lat16 == 0) begin
        lat16 = c; s16 = bus16.out_sum;
      end
      @(posedge clk);
    end
    #1;
    checks += 4;
    if (lat2 != 1) begin
      errors++; $display("FAIL n2_latency: got %0d, expected 1", lat2);
    end
    if (lat16 != 4) begin
      errors++; $display("FAIL n16_latency: got %0d, expected 4", lat16);
    end
    if (s2 !== 5'h1E) begin
      errors++; $display("FAIL n2_sum: got %h, expected 1e", s2);
    end
    if (s16 !== 8'hF0) begin
      errors++; $display("FAIL n16_sum: got %h, expected f0", s16);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    bus2.in_valid   = 1'b0;
    bus2.in_data    = '0;
    bus2.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_data   = '0;
    bus16.out_ready = 1'b1;

    test_reset();
    test_single();
    test_patterns();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_widths();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
